// File: rtl/alu_seq_muldiv_if.sv
// rtl/alu_seq_muldiv_if.sv - request/result bus of the registered ALU with mul/div
interface alu_seq_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             iValid;
    logic             oReady;
    logic [WIDTH-1:0] iDataA;
    logic [WIDTH-1:0] iDataB;
    logic [2:0]       iFunct3;
    logic [6:0]       iFunct7;
    logic             oValid;
    logic [WIDTH-1:0] oData;
    logic             oZero;
    logic             oBusy;

    modport master (
        output iValid, iDataA, iDataB, iFunct3, iFunct7,
        input  oReady, oValid, oData, oZero, oBusy
    );

    modport slave (
        input  iValid, iDataA, iDataB, iFunct3, iFunct7,
        output oReady, oValid, oData, oZero, oBusy
    );
endinterface

// File: rtl/alu_seq_muldiv.sv
// rtl/alu_seq_muldiv.sv - registered RV32I ALU with iterative unsigned multiply/divide
module alu_seq_muldiv #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH),
    localparam int CNTW  = $clog2(WIDTH) + 1
) (
    input logic            iClk,
    input logic            iRst,
    alu_seq_muldiv_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]         state;
    logic [CNTW-1:0]    count;
    logic [WIDTH-1:0]   opA;
    logic [WIDTH-1:0]   opB;
    logic [2:0]         funct3Q;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic               validQ;
    logic [WIDTH-1:0]   dataQ;
    logic               zeroQ;

    logic               isM;
    logic               mLegal;
    logic               isSub;
    logic [WIDTH-1:0]   bOp;
    logic [WIDTH:0]     sumFull;
    logic               overflow;
    logic               slt;
    logic               sltu;
    logic [SHW-1:0]     shamt;
    logic [WIDTH-1:0]   baseResult;
    logic [WIDTH-1:0]   issueResult;

    logic [WIDTH:0]     mulSum;
    logic [2*WIDTH-1:0] prodNext;
    logic [WIDTH:0]     divShift;
    logic [WIDTH:0]     divDiff;
    logic               divOk;
    logic [WIDTH-1:0]   remNext;
    logic [WIDTH-1:0]   quoNext;
    logic [WIDTH-1:0]   mdResult;
    logic               lastIter;

    assign isM    = (bus.iFunct7 == 7'b0000001);
    assign mLegal = (bus.iFunct3 == 3'b000) || (bus.iFunct3 == 3'b011) ||
                    (bus.iFunct3 == 3'b101) || (bus.iFunct3 == 3'b111);

    // SLT/SLTU always subtract so the comparison falls out of the same adder.
    assign isSub    = ((bus.iFunct3 == 3'b000) && bus.iFunct7[5]) ||
                      (bus.iFunct3 == 3'b010) || (bus.iFunct3 == 3'b011);
    assign bOp      = isSub ? ~bus.iDataB : bus.iDataB;
    assign sumFull  = {1'b0, bus.iDataA} + {1'b0, bOp} + {{WIDTH{1'b0}}, isSub};
    assign overflow = (bus.iDataA[WIDTH-1] == bOp[WIDTH-1]) &&
                      (sumFull[WIDTH-1] != bus.iDataA[WIDTH-1]);
    assign slt      = sumFull[WIDTH-1] ^ overflow;
    assign sltu     = ~sumFull[WIDTH];
    assign shamt    = bus.iDataB[SHW-1:0];

    always_comb begin
        baseResult = '0;
        case (bus.iFunct3)
            3'b000:  baseResult = sumFull[WIDTH-1:0];
            3'b001:  baseResult = bus.iDataA << shamt;
            3'b010:  baseResult = {{(WIDTH-1){1'b0}}, slt};
            3'b011:  baseResult = {{(WIDTH-1){1'b0}}, sltu};
            3'b100:  baseResult = bus.iDataA ^ bus.iDataB;
            3'b101:  baseResult = bus.iFunct7[5] ? WIDTH'($signed(bus.iDataA) >>> shamt)
                                                 : (bus.iDataA >> shamt);
            3'b110:  baseResult = bus.iDataA | bus.iDataB;
            default: baseResult = bus.iDataA & bus.iDataB;
        endcase
    end

    assign issueResult = isM ? '0 : baseResult;

    // Shift-add: multiplier sits in the low half and is consumed one bit per cycle.
    assign mulSum   = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opA} : '0);
    assign prodNext = {mulSum, prod[WIDTH-1:1]};

    // Restoring divide; with a zero divisor every step succeeds, giving all-ones / dividend.
    assign divShift = {rem, quo[WIDTH-1]};
    assign divDiff  = divShift - {1'b0, opB};
    assign divOk    = ~divDiff[WIDTH];
    assign remNext  = divOk ? divDiff[WIDTH-1:0] : divShift[WIDTH-1:0];
    assign quoNext  = {quo[WIDTH-2:0], divOk};

    always_comb begin
        mdResult = '0;
        case (funct3Q)
            3'b000:  mdResult = prodNext[WIDTH-1:0];
            3'b011:  mdResult = prodNext[2*WIDTH-1:WIDTH];
            3'b101:  mdResult = quoNext;
            default: mdResult = remNext;
        endcase
    end

    assign lastIter = (count == CNTW'(WIDTH - 1));

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state   <= IDLE;
            count   <= '0;
            opA     <= '0;
            opB     <= '0;
            funct3Q <= '0;
            prod    <= '0;
            rem     <= '0;
            quo     <= '0;
            validQ  <= 1'b0;
            dataQ   <= '0;
            zeroQ   <= 1'b1;
        end else begin
            validQ <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.iValid) begin
                        if (isM && mLegal) begin
                            opA     <= bus.iDataA;
                            opB     <= bus.iDataB;
                            funct3Q <= bus.iFunct3;
                            count   <= '0;
                            if (!bus.iFunct3[2]) begin
                                prod  <= {{WIDTH{1'b0}}, bus.iDataB};
                                state <= MUL;
                            end else begin
                                rem   <= '0;
                                quo   <= bus.iDataA;
                                state <= DIV;
                            end
                        end else begin
                            validQ <= 1'b1;
                            dataQ  <= issueResult;
                            zeroQ  <= (issueResult == '0);
                        end
                    end
                end
                MUL, DIV: begin
                    if (state == MUL) begin
                        prod <= prodNext;
                    end else begin
                        rem <= remNext;
                        quo <= quoNext;
                    end
                    count <= count + 1'b1;
                    if (lastIter) begin
                        state  <= DONE;
                        validQ <= 1'b1;
                        dataQ  <= mdResult;
                        zeroQ  <= (mdResult == '0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.oReady = (state == IDLE);
    assign bus.oBusy  = (state == MUL) || (state == DIV);
    assign bus.oValid = validQ;
    assign bus.oData  = dataQ;
    assign bus.oZero  = zeroQ;
endmodule

// File: doc/alu_seq_muldiv.md
Name: alu_seq_muldiv

Overview:
- Parametrised, registered successor to the combinational RV32I ALU.
- Adds the funct3-selected base ops with a 1-cycle registered result: ADD/SUB, SLL/SRL/SRA, SLT/SLTU, XOR/OR/AND.
- Adds multi-cycle unsigned multiply/divide (funct7 = 0000001) with a valid/ready handshake.
- Sits in the execute stage; the control unit stalls the pipeline on oReady low.

Parameters:
- WIDTH, 32, operand/result width in bits. Must be a power of two, ≥ 8.
- SHW, $clog2(WIDTH), shift-amount bits taken from iDataB[SHW-1:0]. Derived; do not override.
- CNTW, $clog2(WIDTH)+1, iteration counter width. Derived.

Ports:
- iClk  input  1  clock; all state updates on the rising edge.
- iRst  input  1  synchronous, active-high reset.
- iValid  input  1  operation request; sampled only when oReady = 1.
- oReady  output  1  high when the block can accept an operation.
- iDataA  input  WIDTH  operand A (rs1).
- iDataB  input  WIDTH  operand B (rs2 or immediate).
- iFunct3  input  3  operation select.
- iFunct7  input  7  0000000 = base, 0100000 = SUB/SRA, 0000001 = mul/div.
- oValid  output  1  one-cycle pulse: oData/oZero are valid.
- oData  output  WIDTH  result; held until the next oValid.
- oZero  output  1  reduction-NOR of oData, registered with it.
- oBusy  output  1  high while a multi-cycle op is iterating.

Behaviour:
- Reset (synchronous, active-high), required values:
  - oValid = 0, oData = 0, oZero = 1, oBusy = 0, oReady = 1.
  - State = IDLE, counter = 0.
  - Reset mid-iteration aborts the op; no oValid is emitted for it.
- Accept: the cycle where iValid && oReady. Operands and functs are latched on accept.
- States: IDLE, MUL, DIV, DONE.
- Base op (funct7 ≠ 0000001):
  - Stay in IDLE.
  - oValid = 1 and result registered on cycle N+1.
  - oReady stays 1, so back-to-back issue gives one result per cycle.
- Base op functions:
  - 000: ADD, or SUB when funct7[5] = 1.
  - 001: SLL.
  - 101: SRL, or SRA when funct7[5] = 1. Shift amount is iDataB[SHW-1:0].
  - 010: SLT (signed).
  - 011: SLTU. SLT/SLTU result is 1 or 0, zero-extended.
  - 100: XOR. 110: OR. 111: AND.
  - Add/sub reuses the carry-lookahead adder with B-inversion and carry-in = is_sub.
  - SLT = sign of (A−B) xor signed overflow. SLTU = NOT carry-out of A + ~B + 1.
  - Add/sub wraps modulo 2^WIDTH; no overflow flag.
- M op (funct7 = 0000001):
  - 000: MUL (low WIDTH bits).
  - 011: MULHU (high WIDTH bits of the unsigned product).
  - 101: DIVU. 111: REMU.
  - Any other funct3 is illegal: result 0, base-op timing.
- MUL/MULHU:
  - IDLE→MUL; oReady = 0, oBusy = 1.
  - Shift-add over WIDTH iterations using a 2·WIDTH product register.
  - Counter runs 0..WIDTH−1, then →DONE.
- DIVU/REMU:
  - IDLE→DIV; restoring division, one quotient bit per cycle, WIDTH iterations, then →DONE.
  - Divide by zero: quotient = all ones, remainder = iDataA. Same latency as a normal divide (no early exit).
- DONE: oValid = 1 with the selected result, oBusy = 0, then →IDLE.
  - oReady returns to 1 in the cycle after DONE.
- M-op latency: accept at N gives oValid at N+WIDTH+1. oReady is low during N+1..N+WIDTH+1.
- iValid while oReady = 0 is ignored; the requester must hold it.
- oData and oZero change only on oValid cycles.

Test Plan:
- Reset, then ADD 0x7FFFFFFF + 1 issued at cycle 1 → oValid at cycle 2, oData = 0x80000000, oZero = 0. Then SUB 5−5 back-to-back → next cycle oData = 0, oZero = 1.
- SRA 0x80000000 by 31 → 0xFFFFFFFF. SRL same → 0x00000001. SLL 1 by iDataB = 0x21 → 0x00000002 (only the low 5 bits are used).
- SLT 0xFFFFFFFF vs 1 → 1. SLTU same operands → 0.
- MUL 0xFFFFFFFF × 0xFFFFFFFF:
  - MUL → 0x00000001. MULHU → 0xFFFFFFFE.
  - oValid exactly 33 cycles after accept; oReady low for 33 cycles.
  - iValid pulses during busy are dropped.
- DIVU 100/7 → 14. REMU 100/7 → 2. DIVU x/0 → 0xFFFFFFFF. REMU 0x1234/0 → 0x1234.
- Assert iRst at iteration 10 of a DIVU → next cycle oReady = 1, oBusy = 0, no oValid. A following ADD 2+3 → 5 one cycle after accept.
- WIDTH = 8 build: MULHU 0xFF×0xFF → 0xFE with oValid 9 cycles after accept.
